// File: rtl/mux_bus_arbiter_if.sv
// Bus between the round-robin mux arbiter and its four requesters / the dual 4:1 mux.
//   req     : level request per requester (bit i asks for mux input i)
//   sel_a/b : mux select LSB/MSB of the granted index
//   g_n     : active-low mux strobe for both halves
//   grant   : one-hot grant, nonzero only while g_n = 0
//   busy    : arbiter is in SETUP or GRANT
//   preempt : one-cycle pulse after a forced release at the hold limit
`timescale 1ns/1ps
interface mux_bus_arbiter_if;
  logic [3:0] req;
  logic       sel_a;
  logic       sel_b;
  logic       g_n;
  logic [3:0] grant;
  logic       busy;
  logic       preempt;

  // Arbiter side: drives the mux controls and grants.
  modport master (
    input  req,
    output sel_a, sel_b, g_n, grant, busy, preempt
  );

  // Requester / mux side.
  modport slave (
    output req,
    input  sel_a, sel_b, g_n, grant, busy, preempt
  );
endinterface

// File: rtl/mux_bus_arbiter.sv
// Round-robin arbiter sharing one dual 4:1 mux among four requesters. Select
// lines only move while the strobe is high, so the mux never glitches.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : mux_bus_arbiter_if.master (req in; sel_a, sel_b, g_n, grant,
//           busy, preempt out, all registered)
// Parameters:
//   SETUP_CYCLES : cycles of stable select with strobe high before strobing (1..15)
//   HOLD_MAX     : maximum strobe-low cycles per tenure, 0 = unlimited
`timescale 1ns/1ps
module mux_bus_arbiter #(
  parameter int unsigned SETUP_CYCLES = 1,
  parameter int unsigned HOLD_MAX     = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  mux_bus_arbiter_if.master  bus
);

  localparam int unsigned IDX_W      = 2;
  localparam int unsigned SETUP_W    = 4;
  localparam int unsigned SETUP_LAST = (SETUP_CYCLES == 0) ? 0 : SETUP_CYCLES - 1;
  localparam int unsigned HOLD_W     = (HOLD_MAX == 0) ? 1 : $clog2(HOLD_MAX + 1);
  localparam int unsigned HOLD_LAST  = (HOLD_MAX == 0) ? 0 : HOLD_MAX - 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    GRANT = 2'd2
  } state_t;

  state_t               state;
  logic [IDX_W-1:0]     sel;
  logic [IDX_W-1:0]     last;
  logic [SETUP_W-1:0]   setup_cnt;
  logic [HOLD_W-1:0]    hold_cnt;
  logic                 g_n;
  logic [3:0]           grant;
  logic                 busy;
  logic                 preempt;

  logic [IDX_W-1:0]     winner_c;
  logic [IDX_W-1:0]     idx_c;
  logic                 any_req_c;
  logic                 win_req_c;
  logic                 setup_done_c;
  logic                 hold_hit_c;

  // First asserted request searching upward from last+1 with wrap; the
  // descending loop lets the nearest candidate overwrite farther ones.
  always_comb begin
    winner_c = last + 2'd1;
    idx_c    = last + 2'd1;
    for (int k = 3; k >= 0; k--) begin
      idx_c = last + 2'd1 + 2'(k);
      if (bus.req[idx_c]) begin
        winner_c = idx_c;
      end
    end
  end

  // Exit conditions; the selected index doubles as the current winner.
  always_comb begin
    any_req_c    = |bus.req;
    win_req_c    = bus.req[sel];
    setup_done_c = (setup_cnt == SETUP_W'(SETUP_LAST));
    hold_hit_c   = (HOLD_MAX != 0) && (hold_cnt == HOLD_W'(HOLD_LAST));
  end

  // Arbitration FSM with registered mux controls.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      sel       <= '0;
      last      <= 2'd3;
      setup_cnt <= '0;
      hold_cnt  <= '0;
      g_n       <= 1'b1;
      grant     <= '0;
      busy      <= 1'b0;
      preempt   <= 1'b0;
    end else begin
      preempt <= 1'b0;
      case (state)
        IDLE: begin
          // Select may only move here, with the strobe already high.
          if (any_req_c) begin
            sel       <= winner_c;
            setup_cnt <= '0;
            busy      <= 1'b1;
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (!win_req_c) begin
            busy  <= 1'b0;
            state <= IDLE;
          end else if (setup_done_c) begin
            g_n      <= 1'b0;
            grant    <= 4'b0001 << sel;
            last     <= sel;
            hold_cnt <= '0;
            state    <= GRANT;
          end else begin
            setup_cnt <= setup_cnt + SETUP_W'(1);
          end
        end
        GRANT: begin
          if (hold_cnt != '1) begin
            hold_cnt <= hold_cnt + HOLD_W'(1);
          end
          // A simultaneous drop of req counts as a normal release.
          if (!win_req_c || hold_hit_c) begin
            g_n     <= 1'b1;
            grant   <= '0;
            busy    <= 1'b0;
            preempt <= win_req_c;
            state   <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.sel_a   = sel[0];
  assign bus.sel_b   = sel[1];
  assign bus.g_n     = g_n;
  assign bus.grant   = grant;
  assign bus.busy    = busy;
  assign bus.preempt = preempt;

endmodule

// File: tb/tb_mux_bus_arbiter.sv
// Self-checking bench for mux_bus_arbiter: three instances (default, unlimited
// hold, long setup/short hold) share one req stream and are compared each cycle
// against a behavioural model through a scoreboard queue, plus directed tables
// and sequences for rotation, abort, async reset and unlimited hold.
`timescale 1ns/1ps
module tb_mux_bus_arbiter;

  typedef struct packed {
    logic [1:0] sel;
    logic       g_n;
    logic [3:0] grant;
    logic       busy;
    logic       preempt;
  } out_t;

  typedef out_t [2:0] trio_t;

  typedef struct packed {
    logic [3:0] req;
    out_t       exp;
  } vec_t;

  typedef struct {
    int   phase;   // 0 idle, 1 setup, 2 grant
    int   cnt;
    int   last;
    int   win;
    out_t o;
  } mst_t;

  localparam out_t RST_OUT = {2'b00, 1'b1, 4'b0000, 1'b0, 1'b0};

  logic clk = 1'b0;
  logic rst_n;
  int   checks   = 0;
  int   failures = 0;

  int   setup_p [3] = '{1, 1, 3};
  int   hold_p  [3] = '{8, 0, 3};
  mst_t ms      [3];
  out_t prev_o  [3];
  trio_t sbq [$];

  mux_bus_arbiter_if bus0 ();
  mux_bus_arbiter_if bus1 ();
  mux_bus_arbiter_if bus2 ();

  mux_bus_arbiter #(.SETUP_CYCLES(1), .HOLD_MAX(8)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
  mux_bus_arbiter #(.SETUP_CYCLES(1), .HOLD_MAX(0)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  mux_bus_arbiter #(.SETUP_CYCLES(3), .HOLD_MAX(3)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int last);
    for (int k = 1; k <= 4; k++) begin
      if (r[(last + k) % 4]) return (last + k) % 4;
    end
    return -1;
  endfunction

  // Behavioural reference: state after one rising edge with request r.
  function automatic mst_t mstep(input mst_t s, input logic [3:0] r, input int setup, input int hold);
    mst_t n;
    int   w;
    n = s;
    n.o.preempt = 1'b0;
    if (s.phase == 0) begin
      w = pick(r, s.last);
      if (w >= 0) begin
        n.phase  = 1;
        n.win    = w;
        n.cnt    = 1;
        n.o.sel  = 2'(w);
        n.o.busy = 1'b1;
      end
    end else if (s.phase == 1) begin
      if (!r[s.win]) begin
        n.phase  = 0;
        n.o.busy = 1'b0;
      end else if (s.cnt >= setup) begin
        n.phase   = 2;
        n.cnt     = 0;
        n.last    = s.win;
        n.o.g_n   = 1'b0;
        n.o.grant = 4'(1 << s.win);
      end else begin
        n.cnt = s.cnt + 1;
      end
    end else begin
      n.cnt = s.cnt + 1;
      if (!r[s.win] || (hold != 0 && n.cnt >= hold)) begin
        n.phase     = 0;
        n.o.g_n     = 1'b1;
        n.o.grant   = 4'b0000;
        n.o.busy    = 1'b0;
        n.o.preempt = r[s.win];
      end
    end
    return n;
  endfunction

  function automatic vec_t mk(input logic [3:0] r, input logic [1:0] s, input logic gn,
                              input logic [3:0] g, input logic b, input logic p);
    vec_t v;
    v.req = r;
    v.exp = {s, gn, g, b, p};
    return v;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      ms[k].phase = 0;
      ms[k].cnt   = 0;
      ms[k].last  = 3;
      ms[k].win   = 0;
      ms[k].o     = RST_OUT;
      prev_o[k]   = RST_OUT;
    end
    sbq.delete();
  endtask

  task automatic drive_req(input logic [3:0] r);
    bus0.req = r;
    bus1.req = r;
    bus2.req = r;
  endtask

  // One clock: called in the low phase, ends on the following falling edge.
  task automatic cycle(input logic [3:0] r);
    trio_t e;
    trio_t got;
    out_t  a [3];
    drive_req(r);
    for (int k = 0; k < 3; k++) begin
      ms[k] = mstep(ms[k], r, setup_p[k], hold_p[k]);
      e[k]  = ms[k].o;
    end
    sbq.push_back(e);
    @(posedge clk);
    #1;
    a[0] = {bus0.sel_b, bus0.sel_a, bus0.g_n, bus0.grant, bus0.busy, bus0.preempt};
    a[1] = {bus1.sel_b, bus1.sel_a, bus1.g_n, bus1.grant, bus1.busy, bus1.preempt};
    a[2] = {bus2.sel_b, bus2.sel_a, bus2.g_n, bus2.grant, bus2.busy, bus2.preempt};
    if (sbq.size() == 0) begin
      check("sb_empty", 32'(sbq.size()), 32'd1);
    end else begin
      got = sbq.pop_front();
      for (int k = 0; k < 3; k++) begin
        check($sformatf("out%0d", k), 32'(a[k]), 32'(got[k]));
        check($sformatf("onehot%0d", k), 32'($onehot0(a[k].grant)), 32'd1);
        check($sformatf("grant_strobe%0d", k), 32'(a[k].grant != 4'b0000 && a[k].g_n), 32'd0);
        check($sformatf("sel_stable%0d", k),
              32'(a[k].sel != prev_o[k].sel && (!prev_o[k].g_n || !a[k].g_n)), 32'd0);
        prev_o[k] = a[k];
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_req(4'b0000);
    model_reset();
    repeat (2) @(negedge clk);
    check("rst_out0", 32'({bus0.sel_b, bus0.sel_a, bus0.g_n, bus0.grant, bus0.busy, bus0.preempt}), 32'(RST_OUT));
    check("rst_out1", 32'({bus1.sel_b, bus1.sel_a, bus1.g_n, bus1.grant, bus1.busy, bus1.preempt}), 32'(RST_OUT));
    check("rst_out2", 32'({bus2.sel_b, bus2.sel_a, bus2.g_n, bus2.grant, bus2.busy, bus2.preempt}), 32'(RST_OUT));
    rst_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       tab [10];
    logic [3:0] rot [4];
    logic [3:0] r;
    int         nten, tlen, glen, npre, cnt1, pre1, hi;
    logic       pg, found;

    // Grant/release from reset, then abort in SETUP followed by a fresh search.
    tab[0] = mk(4'b0001, 2'b00, 1'b1, 4'b0000, 1'b1, 1'b0);
    tab[1] = mk(4'b0001, 2'b00, 1'b0, 4'b0001, 1'b1, 1'b0);
    tab[2] = mk(4'b0001, 2'b00, 1'b0, 4'b0001, 1'b1, 1'b0);
    tab[3] = mk(4'b0000, 2'b00, 1'b1, 4'b0000, 1'b0, 1'b0);
    tab[4] = mk(4'b0000, 2'b00, 1'b1, 4'b0000, 1'b0, 1'b0);
    tab[5] = mk(4'b0100, 2'b10, 1'b1, 4'b0000, 1'b1, 1'b0);
    tab[6] = mk(4'b0000, 2'b10, 1'b1, 4'b0000, 1'b0, 1'b0);
    tab[7] = mk(4'b0110, 2'b01, 1'b1, 4'b0000, 1'b1, 1'b0);
    tab[8] = mk(4'b0110, 2'b01, 1'b0, 4'b0010, 1'b1, 1'b0);
    tab[9] = mk(4'b0000, 2'b01, 1'b1, 4'b0000, 1'b0, 1'b0);
    rot[0] = 4'b0001;
    rot[1] = 4'b0010;
    rot[2] = 4'b0100;
    rot[3] = 4'b1000;

    rst_n = 1'b0;
    drive_req(4'b0000);
    model_reset();
    do_reset();

    for (int i = 0; i < 10; i++) begin
      if (i == 5) do_reset();
      cycle(tab[i].req);
      check($sformatf("vec%0d", i),
            32'({bus0.sel_b, bus0.sel_a, bus0.g_n, bus0.grant, bus0.busy, bus0.preempt}),
            32'(tab[i].exp));
    end

    // Rotation under constant full request with 8-cycle tenures.
    do_reset();
    nten = 0; tlen = 0; glen = 0; npre = 0; pg = 1'b1;
    for (int c = 0; c < 70 && nten < 5; c++) begin
      cycle(4'b1111);
      if (!bus0.g_n) begin
        if (pg) begin
          if (nten > 0) begin
            check("rr_gap", 32'(glen), 32'd2);
            check("rr_preempt", 32'(npre), 32'd1);
          end
          check("rr_grant", 32'(bus0.grant), 32'(rot[nten % 4]));
          tlen = 0;
        end
        tlen++;
      end else begin
        if (!pg) begin
          check("rr_len", 32'(tlen), 32'd8);
          nten++;
          glen = 0;
          npre = 0;
        end
        glen++;
        if (bus0.preempt) npre++;
      end
      pg = bus0.g_n;
    end
    check("rr_tenures", 32'(nten), 32'd5);

    // Asynchronous reset while requester 2 holds the bus.
    do_reset();
    cycle(4'b0100);
    cycle(4'b0100);
    check("async_pre_grant", 32'(bus0.grant), 32'(4'b0100));
    rst_n = 1'b0;
    #1;
    check("async_g_n", 32'(bus0.g_n), 32'd1);
    check("async_grant", 32'(bus0.grant), 32'd0);
    drive_req(4'b1100);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(4'b1100);
    cycle(4'b1100);
    check("async_first_winner", 32'(bus0.grant), 32'(4'b0100));

    // Unlimited hold on instance 1, then hand-off to requester 1.
    do_reset();
    cnt1 = 0; pre1 = 0;
    for (int c = 0; c < 101; c++) begin
      cycle(4'b0011);
      if (bus1.grant == 4'b0001) cnt1++;
      if (bus1.preempt) pre1++;
    end
    check("nohold_cycles", 32'(cnt1), 32'd100);
    check("nohold_preempt", 32'(pre1), 32'd0);
    hi = 0; found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      cycle(4'b0010);
      if (bus1.grant == 4'b0010) found = 1'b1;
      else if (bus1.g_n) hi++;
    end
    check("handoff_found", 32'(found), 32'd1);
    check("handoff_gap", 32'(hi), 32'd2);

    // Random request stream checked against the model and invariants.
    do_reset();
    r = 4'b0000;
    for (int c = 0; c < 10000; c++) begin
      for (int b = 0; b < 4; b++) begin
        if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
      end
      cycle(r);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
